// File: rtl/bram_uart_top.sv
// rtl/bram_uart_top.sv - UART byte logger in RAM BRAM with replay, ROM string sender and hex display
//
// Ports (bram_uart_top):
//   CLK100MHZ     in   system clock, single clock domain
//   CPU_RESET     in   asynchronous active-high reset
//   BTNL          in   raw button, send the ROM string
//   BTNR          in   raw button, replay the bytes captured in RAM
//   UART_TXD_IN   in   serial data from host, idle high
//   UART_RXD_OUT  out  serial data to host, idle high
//   AN[7:0]       out  digit enables, active-low
//   segment[6:0]  out  cathodes {g,f,e,d,c,b,a}, active-low

module bram_uart_debounce #(
  parameter int CYCLES = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic s1_q, s2_q;
  logic stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rise_q, rise_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
    end else begin
      s1_q     <= btn_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
    end
  end

  // A new level is accepted only after it has differed from the accepted
  // level for CYCLES consecutive clocks; any bounce back restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q != stable_q) begin
      if (cnt_q == LAST) begin
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = stable_d & ~stable_q;
  end

  assign rise_o = rise_q;
endmodule

module bram_uart_rx #(
  parameter int BIT_CYCLES = 5208,
  parameter bit PARITY_ODD = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       valid_o,
  output logic [7:0] data_o
);
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF = CW'(BIT_CYCLES / 2 - 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;

  rx_state_t state_q, state_d;
  logic s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] data_q, data_d;
  logic par_q, par_d;
  logic valid_q, valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      state_q <= R_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s1_q    <= rx_i;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      par_q   <= par_d;
      valid_q <= valid_d;
    end
  end

  // After the start bit is confirmed at its midpoint, every later sample
  // lands one full bit period on, i.e. in the middle of each bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    data_d  = data_q;
    par_d   = par_q;
    valid_d = 1'b0;
    case (state_q)
      R_IDLE: begin
        cnt_d = '0;
        if (!s2_q) state_d = R_START;
      end
      R_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = s2_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d  = '0;
          data_d = {s2_q, data_q[7:1]};
          if (bit_q == 3'd7) state_d = R_PAR;
          else bit_d = bit_q + 1'b1;
        end
      end
      R_PAR: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          par_d   = s2_q;
          state_d = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = R_IDLE;
          valid_d = s2_q && (par_q == (^data_q ^ PARITY_ODD));
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

module bram_uart_tx #(
  parameter int BIT_CYCLES = 5208,
  parameter bit PARITY_ODD = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       busy_o,
  output logic       tx_o
);
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic busy_q, busy_d;
  logic line_q, line_d;
  logic [10:0] shift_q, shift_d;
  logic [3:0] bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      line_q  <= 1'b1;
      shift_q <= '1;
      bit_q   <= '0;
      cnt_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      line_q  <= line_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
    end
  end

  // shift_q holds the whole frame {stop, parity, d7..d0, start}; bit 0 is
  // always the bit currently on the line.
  always_comb begin
    busy_d  = busy_q;
    line_d  = line_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    cnt_d   = '0;
    if (!busy_q) begin
      line_d = 1'b1;
      if (start_i) begin
        busy_d  = 1'b1;
        shift_d = {1'b1, ^data_i ^ PARITY_ODD, data_i, 1'b0};
        line_d  = 1'b0;
        bit_d   = '0;
      end
    end else if (cnt_q == LAST) begin
      if (bit_q == 4'd10) begin
        busy_d = 1'b0;
        line_d = 1'b1;
      end else begin
        bit_d   = bit_q + 1'b1;
        shift_d = {1'b1, shift_q[10:1]};
        line_d  = shift_q[1];
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign busy_o = busy_q;
  assign tx_o   = line_q;
endmodule

module bram_uart_top #(
  parameter int CLK_FREQ        = 100_000_000,
  parameter int BAUD_RATE       = 19_200,
  parameter bit PARITY_ODD      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 100_000,
  parameter int ADDR_WIDTH      = 11,
  parameter int REFRESH_CYCLES  = 100_000
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESET,
  input  logic       BTNL,
  input  logic       BTNR,
  input  logic       UART_TXD_IN,
  output logic       UART_RXD_OUT,
  output logic [7:0] AN,
  output logic [6:0] segment
);
  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int RW         = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);

  localparam SONG_TEXT = {
    "Rise all loyal Cougars and hurl your challenge to the foe. ",
    "You will fight, day or night, rain or snow. ",
    "Loyal, strong, and true, wear the white and blue. ",
    "While we sing, get set to spring. Come on Cougars, it's up to you! ",
    "Oh, rise and shout, the Cougars are out along the trail to fame and glory. ",
    "Rise and shout, our cheers will ring out as you unfold your victory story. ",
    "On you go to win the day, shout for the Cougars as you go! ",
    "For we are here to stay, so forward ever forward to victory!"
  };
  localparam int SONG_BITS  = $bits(SONG_TEXT);
  localparam int SONG_BYTES = SONG_BITS / 8;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_LOAD, S_WAIT} dump_state_t;

  logic clk, rst;
  assign clk = CLK100MHZ;
  assign rst = CPU_RESET;

  logic btnl_rise, btnr_rise;
  logic rx_valid;
  logic [7:0] rx_data;
  logic tx_start, tx_busy, tx_line;
  logic [7:0] rd_byte;

  bram_uart_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_l (
    .clk(clk), .rst(rst), .btn_i(BTNL), .rise_o(btnl_rise));
  bram_uart_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
    .clk(clk), .rst(rst), .btn_i(BTNR), .rise_o(btnr_rise));
  bram_uart_rx #(.BIT_CYCLES(BIT_CYCLES), .PARITY_ODD(PARITY_ODD)) u_rx (
    .clk(clk), .rst(rst), .rx_i(UART_TXD_IN), .valid_o(rx_valid), .data_o(rx_data));
  bram_uart_tx #(.BIT_CYCLES(BIT_CYCLES), .PARITY_ODD(PARITY_ODD)) u_tx (
    .clk(clk), .rst(rst), .start_i(tx_start), .data_i(rd_byte),
    .busy_o(tx_busy), .tx_o(tx_line));

  // ROM image: song text from address 0, zero fill (terminator) after it.
  logic [7:0] rom_mem [DEPTH];
  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    if (g < SONG_BYTES) begin : g_txt
      assign rom_mem[g] = SONG_TEXT[SONG_BITS-8-8*g +: 8];
    end else begin : g_nul
      assign rom_mem[g] = 8'h00;
    end
  end

  logic [7:0] ram_mem [DEPTH];
  logic [7:0] ram_q, rom_q;

  // wr_ptr carries one extra bit so a completely filled RAM is distinguishable
  // from an empty one; once set, further bytes are dropped.
  dump_state_t state_q, state_d;
  logic src_rom_q, src_rom_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] dump_len_q, dump_len_d;
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [7:0] last_rx_q, last_rx_d;
  logic ram_we;

  logic [RW-1:0] refresh_q, refresh_d;
  logic [1:0] digit_q, digit_d;
  logic [7:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic [3:0] nibble;

  always_ff @(posedge clk) begin
    if (ram_we) ram_mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= rx_data;
    ram_q <= ram_mem[rd_ptr_q];
    rom_q <= rom_mem[rd_ptr_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      src_rom_q  <= 1'b0;
      rd_ptr_q   <= '0;
      dump_len_q <= '0;
      wr_ptr_q   <= '0;
      last_rx_q  <= '0;
      refresh_q  <= '0;
      digit_q    <= '0;
      an_q       <= 8'hFF;
      seg_q      <= 7'h7F;
    end else begin
      state_q    <= state_d;
      src_rom_q  <= src_rom_d;
      rd_ptr_q   <= rd_ptr_d;
      dump_len_q <= dump_len_d;
      wr_ptr_q   <= wr_ptr_d;
      last_rx_q  <= last_rx_d;
      refresh_q  <= refresh_d;
      digit_q    <= digit_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  always_comb begin
    ram_we    = rx_valid && !wr_ptr_q[ADDR_WIDTH];
    wr_ptr_d  = ram_we ? wr_ptr_q + 1'b1 : wr_ptr_q;
    last_rx_d = ram_we ? rx_data : last_rx_q;
  end

  assign rd_byte = src_rom_q ? rom_q : ram_q;

  always_comb begin
    state_d    = state_q;
    src_rom_d  = src_rom_q;
    rd_ptr_d   = rd_ptr_q;
    dump_len_d = dump_len_q;
    tx_start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (btnr_rise && (wr_ptr_q != '0)) begin
          src_rom_d  = 1'b0;
          rd_ptr_d   = '0;
          dump_len_d = wr_ptr_q;
          state_d    = S_RD;
        end else if (btnl_rise) begin
          src_rom_d = 1'b1;
          rd_ptr_d  = '0;
          state_d   = S_RD;
        end
      end
      S_RD: state_d = S_LOAD;
      S_LOAD: begin
        if (src_rom_q && (rd_byte == 8'h00)) begin
          state_d = S_IDLE;
        end else begin
          tx_start = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!tx_busy) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if ((!src_rom_q && (({1'b0, rd_ptr_q} + 1'b1) == dump_len_q)) || (rd_ptr_q == '1))
            state_d = S_IDLE;
          else
            state_d = S_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    case (digit_q)
      2'd0:    nibble = last_rx_q[3:0];
      2'd1:    nibble = last_rx_q[7:4];
      2'd2:    nibble = wr_ptr_q[3:0];
      default: nibble = wr_ptr_q[7:4];
    endcase
  end

  // Each tick latches the enable and pattern for digit_q together, so AN and
  // segment never disagree; AN[7:4] stay dark.
  always_comb begin
    refresh_d = refresh_q + 1'b1;
    digit_d   = digit_q;
    an_d      = an_q;
    seg_d     = seg_q;
    if (refresh_q == REFRESH_LAST) begin
      refresh_d = '0;
      digit_d   = digit_q + 1'b1;
      an_d      = {4'hF, ~(4'b0001 << digit_q)};
      seg_d     = hex7(nibble);
    end
  end

  assign UART_RXD_OUT = tx_line;
  assign AN           = an_q;
  assign segment      = seg_q;
endmodule

// File: tb/tb_bram_uart_top.sv
// tb/tb_bram_uart_top.sv - scoreboard bench for bram_uart_top
module tb_bram_uart_top;
  localparam int CLK_FREQ = 160_000;
  localparam int BAUD     = 10_000;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam int DEB      = 20;
  localparam int REF      = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btnl = 1'b0;
  logic btnr = 1'b0;
  logic rx_in = 1'b1;
  logic tx_out;
  logic [7:0] an;
  logic [6:0] seg;

  int n_total = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [9:0] got_q[$];

  always #5 clk = ~clk;

  bram_uart_top #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .PARITY_ODD(1'b1),
    .DEBOUNCE_CYCLES(DEB), .ADDR_WIDTH(11), .REFRESH_CYCLES(REF)
  ) dut (
    .CLK100MHZ(clk), .CPU_RESET(rst), .BTNL(btnl), .BTNR(btnr),
    .UART_TXD_IN(rx_in), .UART_RXD_OUT(tx_out), .AN(an), .segment(seg)
  );

  // Frame monitor: entries are {stop_ok, parity_ok (odd), data}.
  initial begin
    logic [7:0] d;
    logic p, s;
    forever begin
      @(negedge tx_out);
      repeat (BIT / 2) @(negedge clk);
      if (tx_out === 1'b0) begin
        d = '0;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          d[i] = tx_out;
        end
        repeat (BIT) @(negedge clk);
        p = tx_out;
        repeat (BIT) @(negedge clk);
        s = tx_out;
        got_q.push_back({s === 1'b1, p === ~^d, d});
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  task automatic send_byte(input logic [7:0] d, input bit bad_par);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rx_in = f[i];
      repeat (BIT - 1) @(negedge clk);
    end
    repeat (2 * BIT) @(negedge clk);
  endtask

  task automatic get_digit(input int idx, output logic [6:0] s, output bit ok);
    logic [7:0] want_an;
    want_an = ~(8'h01 << idx);
    ok = 1'b0;
    s = 'x;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (an === want_an) begin
        s = seg;
        ok = 1'b1;
      end
    end
  endtask

  task automatic wait_frames(input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < limit && !ok; c++) begin
      @(negedge clk);
      if (got_q.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    int lows;
    logic [6:0] s;
    bit ok;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    n_total++;
    if (tx_out !== 1'b1) begin n_bad++; $display("FAIL reset_line got=%b want=1", tx_out); end
    n_total++;
    if (an !== 8'hFF) begin n_bad++; $display("FAIL reset_an got=%h want=ff", an); end
    rst = 1'b0;
    lows = 0;
    repeat (200) @(negedge clk) if (tx_out !== 1'b1) lows++;
    n_total++;
    if (lows !== 0) begin n_bad++; $display("FAIL reset_idle got=%0d want=0", lows); end
    for (int i = 0; i < 4; i++) begin
      get_digit(i, s, ok);
      n_total++;
      if (!ok || s !== seg_of(4'h0)) begin
        n_bad++; $display("FAIL reset_digit%0d got=%b want=%b", i, s, seg_of(4'h0));
      end
    end
  endtask

  task automatic test_rx;
    logic [7:0] bytes [4];
    logic [3:0] want [4];
    logic [6:0] s;
    bit ok;
    bytes = '{8'h55, 8'hAA, 8'h44, 8'h11};
    want  = '{4'h1, 4'h1, 4'h4, 4'h0};
    for (int i = 0; i < 4; i++) send_byte(bytes[i], 1'b0);
    repeat (50) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      get_digit(i, s, ok);
      n_total++;
      if (!ok || s !== seg_of(want[i])) begin
        n_bad++; $display("FAIL rx_digit%0d got=%b want=%b", i, s, seg_of(want[i]));
      end
    end
  endtask

  task automatic test_ram_dump;
    bit ok;
    logic [9:0] g;
    logic [7:0] e;
    for (int rep = 0; rep < 2; rep++) begin
      got_q.delete();
      exp_q = '{8'h55, 8'hAA, 8'h44, 8'h11};
      btnr = 1'b1;
      wait_frames(4, 1500, ok);
      n_total++;
      if (!ok) begin n_bad++; $display("FAIL dump%0d_timeout got=%0d want=4", rep, got_q.size()); end
      repeat (500) @(negedge clk);
      btnr = 1'b0;
      repeat (400) @(negedge clk);
      n_total++;
      if (got_q.size() !== 4) begin n_bad++; $display("FAIL dump%0d_count got=%0d want=4", rep, got_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
        e = exp_q.pop_front();
        g = got_q.pop_front();
        n_total++;
        if (g !== {2'b11, e}) begin n_bad++; $display("FAIL dump%0d_frame got=%h want=%h", rep, g, {2'b11, e}); end
      end
      exp_q.delete();
    end
  endtask

  task automatic test_bad_parity_and_btnl_ignored;
    logic [6:0] s;
    bit ok;
    logic [9:0] g;
    logic [7:0] e;
    send_byte(8'h77, 1'b1);
    repeat (50) @(negedge clk);
    get_digit(0, s, ok);
    n_total++;
    if (!ok || s !== seg_of(4'h1)) begin n_bad++; $display("FAIL badpar_last got=%b want=%b", s, seg_of(4'h1)); end
    get_digit(2, s, ok);
    n_total++;
    if (!ok || s !== seg_of(4'h4)) begin n_bad++; $display("FAIL badpar_count got=%b want=%b", s, seg_of(4'h4)); end
    got_q.delete();
    exp_q = '{8'h55, 8'hAA, 8'h44, 8'h11};
    btnr = 1'b1;
    repeat (100) @(negedge clk);
    btnr = 1'b0;
    repeat (200) @(negedge clk);
    btnl = 1'b1;
    repeat (100) @(negedge clk);
    btnl = 1'b0;
    repeat (1600) @(negedge clk);
    n_total++;
    if (got_q.size() !== 4) begin n_bad++; $display("FAIL btnl_ignored_count got=%0d want=4", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_total++;
      if (g !== {2'b11, e}) begin n_bad++; $display("FAIL btnl_ignored_frame got=%h want=%h", g, {2'b11, e}); end
    end
    exp_q.delete();
  endtask

  task automatic test_rom_and_reset;
    string txt;
    bit ok;
    bit seen;
    logic [9:0] g;
    logic [7:0] e;
    logic [6:0] s;
    logic [3:0] want [3];
    txt = "Rise all loyal C";
    got_q.delete();
    for (int i = 0; i < txt.len(); i++) exp_q.push_back(txt[i]);
    btnl = 1'b1;
    wait_frames(16, 4000, ok);
    btnl = 1'b0;
    n_total++;
    if (!ok) begin n_bad++; $display("FAIL rom_timeout got=%0d want=16", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_total++;
      if (g !== {2'b11, e}) begin n_bad++; $display("FAIL rom_frame got=%h want=%h", g, {2'b11, e}); end
    end
    exp_q.delete();
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (tx_out === 1'b0) seen = 1'b1;
    end
    repeat (3) @(negedge clk);
    n_total++;
    if (tx_out !== 1'b0) begin n_bad++; $display("FAIL rom_midframe got=%b want=0", tx_out); end
    rst = 1'b1;
    #1;
    n_total++;
    if (tx_out !== 1'b1) begin n_bad++; $display("FAIL reset_abort got=%b want=1", tx_out); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    got_q.delete();
    btnr = 1'b1;
    repeat (100) @(negedge clk);
    btnr = 1'b0;
    repeat (600) @(negedge clk);
    n_total++;
    if (got_q.size() !== 0) begin n_bad++; $display("FAIL empty_dump got=%0d want=0", got_q.size()); end
    send_byte(8'h3C, 1'b0);
    repeat (50) @(negedge clk);
    want = '{4'hC, 4'h3, 4'h1};
    for (int i = 0; i < 3; i++) begin
      get_digit(i, s, ok);
      n_total++;
      if (!ok || s !== seg_of(want[i])) begin
        n_bad++; $display("FAIL post_reset_digit%0d got=%b want=%b", i, s, seg_of(want[i]));
      end
    end
    got_q.delete();
    exp_q.push_back(8'h3C);
    btnr = 1'b1;
    wait_frames(1, 600, ok);
    btnr = 1'b0;
    repeat (300) @(negedge clk);
    n_total++;
    if (got_q.size() !== 1) begin n_bad++; $display("FAIL post_reset_count got=%0d want=1", got_q.size()); end
    if (got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_total++;
      if (g !== {2'b11, e}) begin n_bad++; $display("FAIL post_reset_frame got=%h want=%h", g, {2'b11, e}); end
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_rx();
    test_ram_dump();
    test_bad_parity_and_btnl_ignored();
    test_rom_and_reset();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
